// File: rtl/sd_arb_pkg.sv
// Shared types and widths for the SD sector arbiter.
// Imported by the arbiter top and its round-robin picker.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } state_t;

    localparam int SD_LBA_W  = 32;
    localparam int SD_BYTE_W = 8;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first pending requester after the last grant.
// Purely combinational; the caller registers the result.
module rr_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] pend,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    int c;

    // Walk from the lowest priority slot (last itself) towards the
    // highest so the final hit is the nearest pending after last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        c       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            c = (int'(last) + k) % NREQ;
            if (pend[c]) begin
                gnt_idx = IW'(c);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares the mist_io SD block port between NREQ sector requesters.
// Latches strobes, grants round-robin, runs rd/wr -> ack handshake.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 2**24
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_rd,
    input  logic [NREQ-1:0]           req_wr,
    input  logic [SD_LBA_W*NREQ-1:0]  req_lba,
    input  logic [SD_BYTE_W*NREQ-1:0] req_buff_din,
    output logic [NREQ-1:0]           req_busy,
    output logic [NREQ-1:0]           req_done,
    output logic [NREQ-1:0]           req_err,
    output logic [NREQ-1:0]           req_buff_wr,
    output logic [SD_LBA_W-1:0]       sd_lba,
    output logic                      sd_rd,
    output logic                      sd_wr,
    input  logic                      sd_ack,
    input  logic                      sd_buff_wr,
    output logic [SD_BYTE_W-1:0]      sd_buff_din
);

    localparam int IW = idx_w(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] RR_INIT = IW'(NREQ - 1);

    state_t               state_q, state_d;
    logic [NREQ-1:0]      pend_q, pend_d;
    logic [NREQ-1:0]      dir_q, dir_d;
    logic [IW-1:0]        gnt_q, gnt_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [SD_LBA_W-1:0]  lba_q, lba_d;
    logic [NREQ-1:0]      done_q, done_d;
    logic [NREQ-1:0]      err_q, err_d;

    logic                 ack_m_q, ack_s_q, ack_d_q;
    logic                 ack_rise, ack_fall;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;

    logic [SD_LBA_W-1:0]  lba_a [NREQ];
    logic [SD_BYTE_W-1:0] din_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign lba_a[i] = req_lba[SD_LBA_W*i +: SD_LBA_W];
        assign din_a[i] = req_buff_din[SD_BYTE_W*i +: SD_BYTE_W];
    end

    // sd_ack lives in the SPI clock domain. The synchroniser is left
    // out of reset so a transfer still in flight is seen draining.
    always_ff @(posedge clk_sys) begin
        ack_m_q <= sd_ack;
        ack_s_q <= ack_m_q;
        ack_d_q <= ack_s_q;
    end

    assign ack_rise = ack_s_q & ~ack_d_q;
    assign ack_fall = ~ack_s_q & ack_d_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .pend    (pend_q),
        .last    (rr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Next-state: grant, handshake, timeout and strobe latching.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        dir_d   = dir_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        tcnt_d  = tcnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        lba_d   = lba_q;
        done_d  = '0;
        err_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld && !ack_s_q) begin
                    gnt_d   = arb_idx;
                    rr_d    = arb_idx;
                    tcnt_d  = '0;
                    rd_d    = ~dir_q[arb_idx];
                    wr_d    = dir_q[arb_idx];
                    lba_d   = lba_a[arb_idx];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end else if (tcnt_q == T_LAST) begin
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    err_d[gnt_q]  = 1'b1;
                    pend_d[gnt_q] = 1'b0;
                    state_d       = IDLE;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            XFER: begin
                if (ack_fall) begin
                    done_d[gnt_q] = 1'b1;
                    pend_d[gnt_q] = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strobe is only taken by an idle requester; read wins.
        for (int i = 0; i < NREQ; i++) begin
            if (!pend_q[i] && (req_rd[i] || req_wr[i])) begin
                pend_d[i] = 1'b1;
                dir_d[i]  = ~req_rd[i];
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            dir_q   <= '0;
            gnt_q   <= '0;
            rr_q    <= RR_INIT;
            tcnt_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            lba_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            tcnt_q  <= tcnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            lba_q   <= lba_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Buffer strobes and write data only reach the granted requester
    // while the sector is actually moving.
    always_comb begin
        req_buff_wr = '0;
        sd_buff_din = '0;
        if (state_q == XFER) begin
            req_buff_wr[gnt_q] = sd_buff_wr;
            sd_buff_din        = din_a[gnt_q];
        end
    end

    assign req_busy = pend_q;
    assign req_done = done_q;
    assign req_err  = err_q;
    assign sd_lba   = lba_q;
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Bench for sd_sector_arbiter: mist_io BFM, per-cycle model compare,
// and directed checks with hand-derived latencies and values.
module tb_sd_sector_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_rd, req_wr;
    logic [63:0] req_lba;
    logic [15:0] req_buff_din;
    logic [1:0]  req_busy, req_done, req_err, req_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    sd_sector_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_buff_din (req_buff_din),
        .req_busy     (req_busy),
        .req_done     (req_done),
        .req_err      (req_err),
        .req_buff_wr  (req_buff_wr),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]  m_pend = '0;
    logic [1:0]  m_dir  = '0;
    int          m_svc  = -1;
    bit          m_xfer = 1'b0;
    int          m_wait = 0;
    int          m_rr   = NREQ - 1;
    logic [1:0]  m_done = '0;
    logic [1:0]  m_err  = '0;
    bit          m_rd   = 1'b0;
    bit          m_wr   = 1'b0;
    logic [31:0] m_lba  = '0;
    bit          a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;

    // At each falling edge: check outputs, then step the model using
    // the inputs the DUT will sample at the next rising edge.
    initial begin
        logic [1:0] old, ex_bwr;
        logic [7:0] ex_din;
        bit seen, prev, found;
        int g;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ex_bwr = '0;
                ex_din = '0;
                if (m_svc >= 0 && m_xfer) begin
                    if (sd_buff_wr) ex_bwr = 2'b01 << m_svc;
                    ex_din = req_buff_din[8*m_svc +: 8];
                end
                chk("busy", req_busy, m_pend);
                chk("done", req_done, m_done);
                chk("err", req_err, m_err);
                chk("rdwr", {sd_rd, sd_wr}, {m_rd, m_wr});
                chk("lba", sd_lba, m_lba);
                chk("bwr", req_buff_wr, ex_bwr);
                chk("din", sd_buff_din, ex_din);
            end
            if (reset) begin
                m_pend = '0; m_dir = '0; m_svc = -1; m_xfer = 0;
                m_wait = 0; m_rr = NREQ - 1; m_done = '0; m_err = '0;
                m_rd = 0; m_wr = 0; m_lba = '0;
            end else begin
                seen = a2;
                prev = a3;
                old  = m_pend;
                m_done = '0;
                m_err  = '0;
                if (m_svc < 0) begin
                    if (old != 0 && !seen) begin
                        found = 0;
                        g = 0;
                        for (int k = 1; k <= NREQ; k++) begin
                            if (!found && old[(m_rr + k) % NREQ]) begin
                                g = (m_rr + k) % NREQ;
                                found = 1;
                            end
                        end
                        m_svc = g; m_rr = g; m_xfer = 0; m_wait = 0;
                        m_rd = !m_dir[g]; m_wr = m_dir[g];
                        m_lba = req_lba[32*g +: 32];
                    end
                end else if (!m_xfer) begin
                    if (seen && !prev) begin
                        m_xfer = 1; m_rd = 0; m_wr = 0;
                    end else if (m_wait == TMO - 1) begin
                        m_err[m_svc] = 1; m_pend[m_svc] = 0;
                        m_svc = -1; m_rd = 0; m_wr = 0;
                    end else begin
                        m_wait++;
                    end
                end else if (!seen && prev) begin
                    m_done[m_svc] = 1; m_pend[m_svc] = 0;
                    m_svc = -1; m_xfer = 0;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (!old[i] && (req_rd[i] || req_wr[i])) begin
                        m_pend[i] = 1;
                        m_dir[i]  = !req_rd[i];
                    end
                end
            end
            a3 = a2;
            a2 = a1;
            a1 = sd_ack;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic [1:0] rd, input logic [1:0] wr);
        req_rd = rd;
        req_wr = wr;
        step();
        req_rd = '0;
        req_wr = '0;
    endtask

    task automatic wait_cmd(output int k);
        k = 0;
        while (!(sd_rd || sd_wr) && k < 300) begin
            step();
            k++;
        end
        if (k >= 300) bad("cmd_wait");
    endtask

    // mist_io side: ack after dly cycles, 512 bytes, then ack low.
    task automatic serve(input int dly, output logic [31:0] lba_o,
                         output logic [1:0] rw_o, output int nb0,
                         output int nb1, output logic [7:0] din_o,
                         output int rlat, output int dlat);
        int k;
        wait_cmd(k);
        lba_o = sd_lba;
        rw_o  = {sd_rd, sd_wr};
        repeat (dly) step();
        sd_ack = 1'b1;
        rlat = 0;
        do begin
            step();
            rlat++;
        end while ((sd_rd || sd_wr) && rlat < 50);
        nb0 = 0;
        nb1 = 0;
        din_o = '0;
        for (int b = 0; b < 512; b++) begin
            sd_buff_wr = 1'b1;
            #1;
            nb0 += int'(req_buff_wr[0]);
            nb1 += int'(req_buff_wr[1]);
            if (b == 0) din_o = sd_buff_din;
            step();
            sd_buff_wr = 1'b0;
            step();
        end
        sd_ack = 1'b0;
        dlat = 0;
        do begin
            step();
            dlat++;
        end while (req_done == 0 && dlat < 50);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] lba;
        logic [1:0]  rw;
        logic [7:0]  din;
        logic [31:0] exp_g [4];
        int nb0, nb1, rlat, dlat, k, nstray, nhold;

        reset = 1'b1;
        req_rd = '0; req_wr = '0;
        req_lba = '0; req_buff_din = '0;
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", req_busy, 2'b00);
        chk("rst_rdwr", {sd_rd, sd_wr}, 2'b00);
        chk("rst_lba", sd_lba, 32'h0);
        chk("rst_din", sd_buff_din, 8'h00);

        // 1: read on requester 0
        req_lba = {32'h0000_0010, 32'h0000_0123};
        req_buff_din = {8'hA5, 8'h3C};
        strobe(2'b01, 2'b00);
        chk("t1_busy_next", req_busy, 2'b01);
        wait_cmd(k);
        chk("t1_lat", k + 1, 2);
        serve(4, lba, rw, nb0, nb1, din, rlat, dlat);
        chk("t1_lba", lba, 32'h123);
        chk("t1_rw", rw, 2'b10);
        chk("t1_rlat", rlat, 3);
        chk("t1_nb0", nb0, 512);
        chk("t1_nb1", nb1, 0);
        chk("t1_dlat", dlat, 3);
        chk("t1_done", req_done, 2'b01);

        // 2: write on requester 1
        step();
        strobe(2'b00, 2'b10);
        serve(2, lba, rw, nb0, nb1, din, rlat, dlat);
        chk("t2_lba", lba, 32'h10);
        chk("t2_rw", rw, 2'b01);
        chk("t2_din", din, 8'hA5);
        chk("t2_nb1", nb1, 512);
        chk("t2_nb0", nb0, 0);
        chk("t2_done", req_done, 2'b10);
        step();
        chk("t2_din_after", sd_buff_din, 8'h00);

        // 3: simultaneous reads alternate 0,1,0,1
        exp_g[0] = 32'h123; exp_g[1] = 32'h10;
        exp_g[2] = 32'h123; exp_g[3] = 32'h10;
        for (int r = 0; r < 2; r++) begin
            strobe(2'b11, 2'b00);
            for (int j = 0; j < 2; j++) begin
                serve(3, lba, rw, nb0, nb1, din, rlat, dlat);
                chk($sformatf("t3_grant%0d", 2*r + j), lba, exp_g[2*r + j]);
            end
            step();
        end

        // 6: rd+wr together -> read; strobe while busy ignored
        strobe(2'b01, 2'b01);
        step();
        strobe(2'b00, 2'b01);
        serve(2, lba, rw, nb0, nb1, din, rlat, dlat);
        chk("t6_rw", rw, 2'b10);
        repeat (10) step();
        chk("t6_idle_rdwr", {sd_rd, sd_wr}, 2'b00);
        chk("t6_idle_busy", req_busy, 2'b00);

        // 4: no ack -> timeout
        strobe(2'b01, 2'b00);
        wait_cmd(k);
        k = 0;
        while (!req_err[0] && k < 200) begin
            step();
            k++;
        end
        chk("t4_tmo", k, 64);
        chk("t4_rd", sd_rd, 1'b0);
        chk("t4_busy", req_busy, 2'b00);

        // 5: reset mid-transfer while ack is high
        step();
        strobe(2'b01, 2'b00);
        wait_cmd(k);
        repeat (3) step();
        sd_ack = 1'b1;
        repeat (6) step();
        for (int b = 0; b < 100; b++) begin
            sd_buff_wr = 1'b1;
            step();
            sd_buff_wr = 1'b0;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rdwr", {sd_rd, sd_wr}, 2'b00);
        chk("t5_busy", req_busy, 2'b00);
        strobe(2'b10, 2'b00);
        nstray = 0;
        nhold  = 0;
        for (int b = 101; b < 512; b++) begin
            sd_buff_wr = 1'b1;
            #1;
            nstray += int'(req_buff_wr != 0);
            nhold  += int'(sd_rd || sd_wr);
            step();
            sd_buff_wr = 1'b0;
            step();
        end
        chk("t5_stray", nstray, 0);
        chk("t5_hold", nhold, 0);
        chk("t5_pend", req_busy, 2'b10);
        sd_ack = 1'b0;
        k = 0;
        while (!(sd_rd || sd_wr) && k < 50) begin
            step();
            k++;
        end
        chk("t5_lat", k, 3);
        serve(2, lba, rw, nb0, nb1, din, rlat, dlat);
        chk("t5_lba", lba, 32'h10);
        chk("t5_nb1", nb1, 512);
        chk("t5_done", req_done, 2'b10);

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
